// File: rtl/i2c_slv_rx_irq.sv
// i2c_slv_rx_irq
//   Receive-only I2C target. It answers a host write stream (START, addr+W, N data
//   bytes, STOP) by oversampling SCL/SDA on clk_i. It ACKs its own address and each
//   data byte, and queues the bytes in a small FIFO that the APB side drains. A level
//   interrupt is raised when the FIFO reaches a fill threshold, at end of transfer, or
//   on overflow.
//
//   Optional build macro: I2C_SLV_GLITCH_FILTER_EN. When it is defined, a 3-sample
//   majority filter sits after the synchronizer on both lines. Edges are then seen
//   5 clk after the pad changes, and pulses shorter than 2 clk are rejected. When it
//   is undefined, edges are seen 3 clk after the pad changes and every synced toggle
//   counts.
//
// Ports
//   clk_i       single clock, at least 8x the SCL rate
//   rst_i       synchronous reset, active high
//   scl_i/sda_i asynchronous pad inputs
//   sda_oe_o    1 = pull SDA low (open-drain ACK)
//   slv_addr_i  own 7-bit address, quasi-static
//   irq_en_i    gates irq_o
//   irq_clr_i   one-cycle pulse that clears the eot and overflow sticky flags
//   rdata_o     FIFO head byte; holds the last head while the FIFO is empty
//   rvalid_o    FIFO is not empty
//   rready_i    pops the FIFO when rvalid_o is also high
//   level_o     current FIFO occupancy
//   overflow_o  sticky: a byte arrived while the FIFO was full
//   irq_o       registered level interrupt
module i2c_slv_rx_irq #(
  parameter int FIFO_DEPTH = 8,
  parameter int IRQ_THRESH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          scl_i,
  input  logic                          sda_i,
  output logic                          sda_oe_o,
  input  logic [6:0]                    slv_addr_i,
  input  logic                          irq_en_i,
  input  logic                          irq_clr_i,
  output logic [7:0]                    rdata_o,
  output logic                          rvalid_o,
  input  logic                          rready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overflow_o,
  output logic                          irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  // ---------------------------------------------------------------- input path
  // Bit 0 is SCL and bit 1 is SDA. All stages preset to 1 so that a reset looks
  // like an idle bus.
  logic [1:0] pad_in;
  logic [1:0] line_cur;
  logic [1:0] line_hist;

  assign pad_in = {sda_i, scl_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic sync1_reg;
      logic sync2_reg;
      logic hist_reg;
`ifdef I2C_SLV_GLITCH_FILTER_EN
      logic [2:0] samp_reg;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          samp_reg  <= 3'b111;
          hist_reg  <= 1'b1;
        end else begin
          sync1_reg <= pad_in[gi];
          sync2_reg <= sync1_reg;
          samp_reg  <= {samp_reg[1:0], sync2_reg};
          hist_reg  <= line_cur[gi];
        end
      end
      // A single-clock pulse occupies only one of the three samples, so it never wins the vote.
      assign line_cur[gi] = (samp_reg[0] & samp_reg[1]) | (samp_reg[1] & samp_reg[2]) |
                            (samp_reg[0] & samp_reg[2]);
`else
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          hist_reg  <= 1'b1;
        end else begin
          sync1_reg <= pad_in[gi];
          sync2_reg <= sync1_reg;
          hist_reg  <= sync2_reg;
        end
      end
      assign line_cur[gi] = sync2_reg;
`endif
      assign line_hist[gi] = hist_reg;
    end
  endgenerate

  logic scl_s, scl_d, sda_s, sda_d;
  logic start_det, stop_det, scl_rise, scl_fall;

  assign scl_s     = line_cur[0];
  assign scl_d     = line_hist[0];
  assign sda_s     = line_cur[1];
  assign sda_d     = line_hist[1];
  // A START or STOP needs SCL high in both samples, and a bit sample needs an SCL
  // rise. The two can never coincide, so START/STOP always take priority.
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;

  // ---------------------------------------------------------------- FSM
  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_DATA, ST_DATA_ACK, ST_IGNORE
  } state_t;

  state_t      state_reg;
  logic [2:0]  bit_cnt_reg;
  logic [6:0]  shift_reg;
  logic        sda_oe_reg;
  logic        pushed_reg;   // at least one byte has been queued since the last START
  logic        eot_reg;
  logic        ovf_reg;

  logic [7:0]    byte_next;
  logic          byte_done;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic [LW-1:0] count_reg;

  assign byte_next = {shift_reg, sda_s};
  assign byte_done = scl_rise & (bit_cnt_reg == 3'd7);
  assign fifo_full = (count_reg == LW'(FIFO_DEPTH));
  assign push      = (state_reg == ST_DATA) & byte_done & ~fifo_full;
  assign pop       = rready_i & (count_reg != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= 3'd0;
      shift_reg   <= 7'd0;
      sda_oe_reg  <= 1'b0;
      pushed_reg  <= 1'b0;
      eot_reg     <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      // The clear is written first, so any set later in this block overrides it.
      if (irq_clr_i) begin
        eot_reg <= 1'b0;
        ovf_reg <= 1'b0;
      end
      if (start_det) begin
        state_reg   <= ST_ADDR;
        bit_cnt_reg <= 3'd0;
        sda_oe_reg  <= 1'b0;
        pushed_reg  <= 1'b0;
      end else if (stop_det) begin
        state_reg  <= ST_IDLE;
        sda_oe_reg <= 1'b0;
        if (pushed_reg) eot_reg <= 1'b1;
      end else begin
        case (state_reg)
          ST_ADDR: if (scl_rise) begin
            shift_reg   <= byte_next[6:0];
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7)
              state_reg <= (byte_next[7:1] == slv_addr_i && !byte_next[0]) ? ST_ADDR_ACK
                                                                            : ST_IGNORE;
          end
          // ACK window: SDA is pulled low on the 8th SCL fall and released on the 9th.
          ST_ADDR_ACK, ST_DATA_ACK: if (scl_fall) begin
            if (!sda_oe_reg) begin
              sda_oe_reg <= 1'b1;
            end else begin
              sda_oe_reg  <= 1'b0;
              state_reg   <= ST_DATA;
              bit_cnt_reg <= 3'd0;
            end
          end
          ST_DATA: if (scl_rise) begin
            shift_reg   <= byte_next[6:0];
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              if (!fifo_full) begin
                state_reg  <= ST_DATA_ACK;
                pushed_reg <= 1'b1;
              end else begin
                ovf_reg   <= 1'b1;
                state_reg <= ST_IGNORE;
              end
            end
          end
          ST_IGNORE: sda_oe_reg <= 1'b0;
          default:   sda_oe_reg <= 1'b0;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0] count_next;
  logic [7:0]    rdata_reg, head_next;
  logic          irq_reg;

  assign rd_ptr_next = rd_ptr_reg + AW'(pop);
  assign count_next  = count_reg + LW'(push) - LW'(pop);

  // The head is kept in a register. When the FIFO was empty, or is about to become
  // empty, the byte being pushed in this cycle becomes the new head directly.
  always_comb begin
    head_next = rdata_reg;
    if (count_next != '0) begin
      if ((count_reg - LW'(pop)) == '0) head_next = byte_next;
      else                               head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem[wr_ptr_reg] <= byte_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      rdata_reg  <= 8'd0;
      irq_reg    <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      rdata_reg  <= head_next;
      irq_reg    <= irq_en_i & ((count_reg >= LW'(IRQ_THRESH)) | eot_reg | ovf_reg);
    end
  end

  assign sda_oe_o   = sda_oe_reg;
  assign rdata_o    = rdata_reg;
  assign rvalid_o   = (count_reg != '0);
  assign level_o    = count_reg;
  assign overflow_o = ovf_reg;
  assign irq_o      = irq_reg;

endmodule
